dmadd_cmd_sequencer: RTL and testbench
======================================

Name: dmadd_cmd_sequencer

Overview:
- Upstream command sequencer for the delta-MADD min/max engine.
- Accepts packed host commands over a valid/ready handshake and buffers them in a small FIFO.
- Expands each command into cycle-exact engine strobes: index, data, insn, load, run, and an engine reset.
- After each run burst, captures the engine's 12-bit result and presents it with a one-cycle valid pulse.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of two, minimum 2.
- CLR_CYCLES, 2, cycles the engine reset is held low for a CLEAR command.
- SETTLE_CYCLES, 1, idle cycles after a run burst before the result is captured.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  FIFO not full.
- cmd_data  in  10  {op[1:0], index[3:0], data[3:0]}.
- eng_rst_n  out  1  engine reset, active low.
- eng_index  out  4  engine index.
- eng_data  out  4  engine data.
- eng_insn  out  2  engine instruction (current mode).
- eng_load  out  1  engine load strobe.
- eng_run  out  1  engine run strobe.
- eng_out  in  8  engine result, low 8 bits.
- eng_out_top  in  4  engine result, high 4 bits.
- result  out  12  captured {eng_out_top, eng_out}.
- result_valid  out  1  one-cycle pulse when result updates.
- busy  out  1  FSM not in IDLE, or FIFO not empty.

Behaviour:
- Reset values (asynchronous, on rst=1):
  - FIFO empty; FSM in IDLE; mode=2'b00.
  - eng_rst_n=0 while rst is high, then 1.
  - eng_load=0, eng_run=0, eng_index=0, eng_data=0, eng_insn=0.
  - result=0, result_valid=0, busy=0.
- Handshake:
  - A push occurs when cmd_valid && cmd_ready.
  - cmd_ready = !full, registered from the occupancy count.
  - A simultaneous push and pop when full is not allowed, because ready is already low.
  - Push and pop in the same cycle otherwise keep the count unchanged.
- Ops:
  - 00 CLEAR: mode<=data[1:0]; eng_rst_n=0 for CLR_CYCLES cycles.
  - 01 LOAD: one cycle with eng_load=1 and eng_index/eng_data = command fields.
  - 10 RUN: eng_run=1 for N consecutive cycles, where N = data, and data==0 means 16. Then SETTLE_CYCLES idle cycles, then capture.
  - 11 MODE: mode<=data[1:0]; one cycle with load=0, run=0, insn = new mode (engine init pulse).
- FSM states and transitions:
  - IDLE: pop the FIFO head if non-empty, then enter CLR, LOAD, RUN or MODE.
  - CLR: after CLR_CYCLES, go to IDLE.
  - LOAD: after 1 cycle, go to IDLE.
  - MODE: after 1 cycle, go to IDLE.
  - RUN: when the run counter reaches 0, go to SETTLE.
  - SETTLE: after SETTLE_CYCLES, go to CAPTURE.
  - CAPTURE: latch result; result_valid=1 for exactly 1 cycle; go to IDLE.
- Timing:
  - Pop-to-first-strobe latency: 1 cycle. All eng_* outputs are registered.
  - Back-to-back LOADs from a non-empty FIFO issue one load per 2 cycles (IDLE + LOAD).
- eng_insn always equals mode. It changes only on the cycle after a CLEAR or MODE pop.
- Outside LOAD, eng_index/eng_data hold their last values; only the strobes return to 0.
- Run counter: 5 bits, loaded with N, decremented while in RUN. Exactly N run cycles are issued, with no off-by-one at N=16.
- Mid-operation reset: returns to reset values immediately, and any FIFO contents are discarded.
- result holds its value until the next CAPTURE.

Optional Feature:
- Macro: DMADD_CMD_PARITY_EN.
- With the macro:
  - Extra input cmd_par (1 bit) and extra output par_err (1 bit, sticky).
  - The even-parity check covers {cmd_data, cmd_par}.
  - A failing command is accepted (handshake completes) but not written to the FIFO; par_err<=1.
  - par_err is cleared only by rst or by a valid CLEAR op.
- Without the macro: neither port exists and all commands are stored.

Decomposition:
- Shared package dmadd_pkg:
  - op encodings OP_CLEAR, OP_LOAD, OP_RUN, OP_MODE.
  - insn/mode encodings MODE_MIN=00, MODE_MAX=01, MODE_MADD=10.
  - FSM state enum.
  - cmd field bit positions.
  - RESULT_W=12.
- Sub-module dmadd_cmd_fifo: synchronous FIFO with push/pop, full/empty, and a count parameterised by FIFO_DEPTH. The sequencer instantiates one.

Test Plan:
- Reset: assert rst mid-RUN burst (N=8) → all strobes 0 and cmd_ready=1 at once; busy=0; a FIFO holding 3 commands is emptied.
- CLEAR(data=01) then MODE(data=00) → eng_rst_n low for exactly 2 cycles and insn=01; then one init cycle with insn=00 and load=run=0.
- LOAD idx=5 data=9 → exactly one cycle with eng_load=1, eng_index=5, eng_data=9, one cycle after the pop.
- RUN data=0 with engine model → eng_run high exactly 16 cycles; 1 settle cycle; result={out_top,out} sampled then (e.g. 12'h0A3); result_valid high 1 cycle.
- FIFO full: push 5 commands with the FSM stalled in RUN (N=16) → cmd_ready drops after 4 accepted; the fifth is held; all execute in order.
- Parity (macro on): command with a wrong cmd_par → no strobes issued, par_err=1 and stays set until a CLEAR.

Source files
------------

// File: rtl/dmadd_pkg.sv
// Shared encodings for the delta-MADD command sequencer: ops, engine modes,
// sequencer FSM states and the packed host command layout.
package dmadd_pkg;

  localparam int RESULT_W = 12;
  localparam int CMD_W    = 10;

  // Host command bit positions: {op[1:0], index[3:0], data[3:0]}
  localparam int OP_HI  = 9;
  localparam int OP_LO  = 8;
  localparam int IDX_HI = 7;
  localparam int IDX_LO = 4;
  localparam int DAT_HI = 3;
  localparam int DAT_LO = 0;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'b00,
    OP_LOAD  = 2'b01,
    OP_RUN   = 2'b10,
    OP_MODE  = 2'b11
  } op_e;

  localparam logic [1:0] MODE_MIN  = 2'b00;
  localparam logic [1:0] MODE_MAX  = 2'b01;
  localparam logic [1:0] MODE_MADD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD,
    S_MODE,
    S_RUN,
    S_SETTLE,
    S_CAPTURE
  } state_e;

  typedef struct packed {
    op_e        op;
    logic [3:0] index;
    logic [3:0] data;
  } cmd_t;

  // Run burst length: a data field of zero encodes the maximum burst of 16.
  function automatic logic [4:0] run_len(input logic [3:0] d);
    return (d == 4'd0) ? 5'd16 : {1'b0, d};
  endfunction

endpackage

// File: rtl/dmadd_cmd_fifo.sv
// Small synchronous command FIFO with occupancy count. DEPTH must be a power
// of two so the pointers wrap naturally.
module dmadd_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rp];

  // Storage: no reset needed, validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

  // Pointers and occupancy; reset discards any queued entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dmadd_cmd_sequencer.sv
// Command sequencer for the delta-MADD min/max engine: buffers host commands
// and expands them into registered engine strobes, then captures results.
// Optional command parity checking: define DMADD_CMD_PARITY_EN.
module dmadd_cmd_sequencer
  import dmadd_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int CLR_CYCLES    = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
`ifdef DMADD_CMD_PARITY_EN
  input  logic                cmd_par,
  output logic                par_err,
`endif
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [CMD_W-1:0]    cmd_data,
  output logic                eng_rst_n,
  output logic [3:0]          eng_index,
  output logic [3:0]          eng_data,
  output logic [1:0]          eng_insn,
  output logic                eng_load,
  output logic                eng_run,
  input  logic [7:0]          eng_out,
  input  logic [3:0]          eng_out_top,
  output logic [RESULT_W-1:0] result,
  output logic                result_valid,
  output logic                busy
);

  localparam int         CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [4:0] CLR_N = 5'(CLR_CYCLES);
  localparam logic [4:0] SET_N = 5'(SETTLE_CYCLES);

  state_e           state, state_nx;
  logic [4:0]       cnt, cnt_nx;
  logic             push, pop, full, empty;
  logic [CW-1:0]    count;
  logic [CMD_W-1:0] head_raw;
  cmd_t             head;

  assign head      = cmd_t'(head_raw);
  assign cmd_ready = !full;
  assign busy      = (state != S_IDLE) || (count != '0);

`ifdef DMADD_CMD_PARITY_EN
  logic par_ok;
  assign par_ok = ~^{cmd_data, cmd_par};
  // Bad-parity commands complete the handshake but are dropped.
  assign push   = cmd_valid && cmd_ready && par_ok;

  // Sticky parity error, cleared only by a CLEAR reaching execution.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   par_err <= 1'b0;
    else if (cmd_valid && cmd_ready && !par_ok) par_err <= 1'b1;
    else if (pop && head.op == OP_CLEAR)       par_err <= 1'b0;
  end
`else
  assign push = cmd_valid && cmd_ready;
`endif

  dmadd_cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(CMD_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (cmd_data),
    .rdata (head_raw),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // State and shared cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next state: one counter serves the clear hold, the run burst and settle.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pop      = 1'b0;
    case (state)
      S_IDLE: if (!empty) begin
        pop = 1'b1;
        case (head.op)
          OP_CLEAR: begin state_nx = S_CLR; cnt_nx = CLR_N; end
          OP_LOAD:  state_nx = S_LOAD;
          OP_RUN:   begin state_nx = S_RUN; cnt_nx = run_len(head.data); end
          default:  state_nx = S_MODE;
        endcase
      end
      S_CLR: begin
        cnt_nx = cnt - 1'b1;
        if (cnt <= 5'd1) state_nx = S_IDLE;
      end
      S_LOAD, S_MODE: state_nx = S_IDLE;
      S_RUN: begin
        cnt_nx = cnt - 1'b1;
        if (cnt <= 5'd1) begin
          if (SETTLE_CYCLES == 0) state_nx = S_CAPTURE;
          else begin state_nx = S_SETTLE; cnt_nx = SET_N; end
        end
      end
      S_SETTLE: begin
        cnt_nx = cnt - 1'b1;
        if (cnt <= 5'd1) state_nx = S_CAPTURE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Engine outputs registered from the next state, so strobes appear one
  // cycle after the pop; index/data/insn hold between their updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_rst_n    <= 1'b0;
      eng_load     <= 1'b0;
      eng_run      <= 1'b0;
      eng_index    <= '0;
      eng_data     <= '0;
      eng_insn     <= MODE_MIN;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      eng_rst_n    <= (state_nx != S_CLR);
      eng_load     <= (state_nx == S_LOAD);
      eng_run      <= (state_nx == S_RUN);
      result_valid <= (state_nx == S_CAPTURE);
      if (state_nx == S_CAPTURE) result <= {eng_out_top, eng_out};
      if (pop && head.op == OP_LOAD) begin
        eng_index <= head.index;
        eng_data  <= head.data;
      end
      if (pop && (head.op == OP_CLEAR || head.op == OP_MODE))
        eng_insn <= head.data[1:0];
    end
  end

endmodule

// File: tb/tb_dmadd_cmd_sequencer.sv
// Bench for dmadd_cmd_sequencer: directed timing checks plus a random command
// stream scored against an event-level model (loads, bursts, clears, results).
module tb_dmadd_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  cmd_data = '0;
  logic        eng_rst_n, eng_load, eng_run, result_valid, busy;
  logic [3:0]  eng_index, eng_data, eng_out_top;
  logic [1:0]  eng_insn;
  logic [7:0]  eng_out;
  logic [11:0] result;
`ifdef DMADD_CMD_PARITY_EN
  logic        cmd_par = 1'b0;
  logic        par_err;
`endif

  always #5 clk = ~clk;

  dmadd_cmd_sequencer dut (
    .clk(clk), .rst(rst),
`ifdef DMADD_CMD_PARITY_EN
    .cmd_par(cmd_par), .par_err(par_err),
`endif
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .eng_rst_n(eng_rst_n), .eng_index(eng_index), .eng_data(eng_data),
    .eng_insn(eng_insn), .eng_load(eng_load), .eng_run(eng_run),
    .eng_out(eng_out), .eng_out_top(eng_out_top),
    .result(result), .result_valid(result_valid), .busy(busy)
  );

  int nvec = 0, nfail = 0;

  // Engine stand-in: result is a scrambled count of run cycles since its reset.
  function automatic logic [11:0] eng_f(input logic [11:0] a);
    logic [11:0] r;
    r = a * 12'h0B1;
    return r ^ 12'h0A3;
  endfunction

  logic [11:0] acc;
  always @(posedge clk or posedge rst)
    if (rst)             acc <= '0;
    else if (!eng_rst_n) acc <= '0;
    else if (eng_run)    acc <= acc + 12'd1;
  assign {eng_out_top, eng_out} = eng_f(acc);

  // Expected and observed event streams.
  logic [9:0]  exp_ld[$],  act_ld[$];
  logic [6:0]  exp_run[$], act_run[$];
  logic [4:0]  exp_clr[$], act_clr[$];
  logic [11:0] exp_res[$], act_res[$];
  logic [1:0]  m_mode = 2'b00;
  logic [11:0] m_acc = '0;
  bit          model_on = 1'b0, mon_en = 1'b0;
  int          last_wait, rv_dbl = 0;

  // Monitor: collapse cycle activity into events.
  int run_len = 0, clr_len = 0;
  logic [1:0] run_insn;
  bit rv_prev = 1'b0;
  always @(negedge clk) begin
    if (rst || !mon_en) begin
      run_len = 0; clr_len = 0; rv_prev = 1'b0;
    end else begin
      if (eng_load) act_ld.push_back({eng_insn, eng_index, eng_data});
      if (eng_run) begin
        if (run_len == 0) run_insn = eng_insn;
        run_len++;
      end else if (run_len != 0) begin
        act_run.push_back({run_insn, run_len[4:0]}); run_len = 0;
      end
      if (!eng_rst_n) clr_len++;
      else if (clr_len != 0) begin act_clr.push_back(clr_len[4:0]); clr_len = 0; end
      if (result_valid) begin
        act_res.push_back(result);
        if (rv_prev) rv_dbl++;
      end
      rv_prev = result_valid;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: what each command should make the engine see, in order.
  task automatic model_apply(input logic [1:0] op, input logic [3:0] idx, input logic [3:0] dat);
    logic [4:0] n;
    case (op)
      2'b00: begin m_mode = dat[1:0]; m_acc = '0; exp_clr.push_back(5'd2); end
      2'b01: exp_ld.push_back({m_mode, idx, dat});
      2'b10: begin
        n = (dat == 4'd0) ? 5'd16 : {1'b0, dat};
        m_acc = m_acc + 12'(n);
        exp_run.push_back({m_mode, n});
        exp_res.push_back(eng_f(m_acc));
      end
      default: m_mode = dat[1:0];
    endcase
  endtask

  // Offer one command, retrying while not ready; returns #1 after acceptance.
  task automatic push_cmd(input logic [1:0] op, input logic [3:0] idx, input logic [3:0] dat,
                          input bit bad);
    bit hs = 1'b0;
    last_wait = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = {op, idx, dat};
`ifdef DMADD_CMD_PARITY_EN
    cmd_par = (^{op, idx, dat}) ^ bad;
`endif
    while (!hs) begin
      hs = cmd_ready;
      @(posedge clk);
      if (!hs) begin
        last_wait++;
        if (last_wait > 300) begin
          nvec++; nfail++;
          $error("FAIL push_timeout: observed %0d cycles expected accept", last_wait);
          break;
        end
        @(negedge clk);
      end
    end
    #1 cmd_valid = 1'b0;
    if (model_on && !bad) model_apply(op, idx, dat);
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (busy && t < 500) begin @(negedge clk); t++; end
    if (t >= 500) begin
      nvec++; nfail++;
      $error("FAIL idle_timeout: observed busy after %0d cycles expected idle", t);
    end
  endtask

  task automatic compare_drain();
    wait_idle();
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    chk("load_count", act_ld.size(), exp_ld.size());
    for (int i = 0; i < exp_ld.size() && i < act_ld.size(); i++) chk("load_evt", act_ld[i], exp_ld[i]);
    chk("run_count", act_run.size(), exp_run.size());
    for (int i = 0; i < exp_run.size() && i < act_run.size(); i++) chk("run_evt", act_run[i], exp_run[i]);
    chk("clr_count", act_clr.size(), exp_clr.size());
    for (int i = 0; i < exp_clr.size() && i < act_clr.size(); i++) chk("clr_len", act_clr[i], exp_clr[i]);
    chk("res_count", act_res.size(), exp_res.size());
    for (int i = 0; i < exp_res.size() && i < act_res.size(); i++) chk("result", act_res[i], exp_res[i]);
    chk("rv_single", rv_dbl, 0);
    exp_ld.delete(); act_ld.delete(); exp_run.delete(); act_run.delete();
    exp_clr.delete(); act_clr.delete(); exp_res.delete(); act_res.delete();
  endtask

  initial begin
    int rc;
    // ---- reset values
    repeat (3) @(negedge clk);
    chk("rst_eng_rst_n", eng_rst_n, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_load", eng_load, 0);
    chk("rst_run", eng_run, 0);
    chk("rst_index", eng_index, 0);
    chk("rst_data", eng_data, 0);
    chk("rst_insn", eng_insn, 0);
    chk("rst_result", result, 0);
    chk("rst_rv", result_valid, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_eng_rst_n", eng_rst_n, 1);
    mon_en = 1'b1; model_on = 1'b1;

    // ---- CLEAR(01) then MODE(00)
    push_cmd(2'b00, 4'd0, 4'b0001, 1'b0);
    push_cmd(2'b11, 4'd0, 4'b0000, 1'b0);
    @(negedge clk); chk("clr_k1_rst_n", eng_rst_n, 0); chk("clr_k1_insn", eng_insn, 2'b01);
    @(negedge clk); chk("clr_k2_rst_n", eng_rst_n, 0);
    @(negedge clk); chk("clr_k3_rst_n", eng_rst_n, 1); chk("clr_k3_insn", eng_insn, 2'b01);
    @(negedge clk); chk("mode_insn", eng_insn, 2'b00);
    chk("mode_load", eng_load, 0); chk("mode_run", eng_run, 0);
    @(negedge clk); chk("mode_done_busy", busy, 0);

    // ---- LOAD idx=5 data=9
    wait_idle();
    push_cmd(2'b01, 4'd5, 4'd9, 1'b0);
    @(negedge clk); chk("ld_k0_load", eng_load, 0);
    @(negedge clk); chk("ld_k1_load", eng_load, 1);
    chk("ld_k1_index", eng_index, 5); chk("ld_k1_data", eng_data, 9);
    @(negedge clk); chk("ld_k2_load", eng_load, 0);
    chk("ld_hold_index", eng_index, 5); chk("ld_hold_data", eng_data, 9);

    // ---- RUN data=0: 16 run cycles, one settle cycle, then result
    wait_idle();
    push_cmd(2'b10, 4'd0, 4'd0, 1'b0);
    @(negedge clk);
    rc = 0;
    for (int k = 1; k <= 16; k++) begin @(negedge clk); if (eng_run) rc++; end
    chk("run16_cycles", rc, 16);
    @(negedge clk); chk("settle_run", eng_run, 0); chk("settle_rv", result_valid, 0);
    @(negedge clk); chk("cap_rv", result_valid, 1); chk("cap_result", result, eng_f(12'd16));
    @(negedge clk); chk("cap_rv_drop", result_valid, 0); chk("cap_hold", result, eng_f(12'd16));

    // ---- FIFO full while stalled in a 16-cycle RUN
    wait_idle();
    push_cmd(2'b10, 4'd0, 4'd0, 1'b0);
    for (int i = 0; i < 4; i++) push_cmd(2'b01, 4'(i), 4'(15 - i), 1'b0);
    chk("full_ready_low", cmd_ready, 0);
    push_cmd(2'b01, 4'd4, 4'd11, 1'b0);
    chk("fifth_held", last_wait >= 10, 1);
    compare_drain();

    // ---- reset mid-burst with three commands queued
    mon_en = 1'b0; model_on = 1'b0;
    push_cmd(2'b10, 4'd0, 4'd8, 1'b0);
    for (int i = 0; i < 3; i++) push_cmd(2'b01, 4'(i), 4'd3, 1'b0);
    @(negedge clk);
    chk("mid_run_active", eng_run, 1);
    rst = 1'b1;
    #1;
    chk("mrst_run", eng_run, 0); chk("mrst_load", eng_load, 0);
    chk("mrst_ready", cmd_ready, 1); chk("mrst_busy", busy, 0);
    chk("mrst_eng_rst_n", eng_rst_n, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_mode = 2'b00; m_acc = '0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    repeat (10) @(negedge clk);
    chk("mrst_no_loads", act_ld.size(), 0);
    chk("mrst_no_runs", act_run.size(), 0);
    chk("mrst_idle", busy, 0);

    // ---- random command stream
    model_on = 1'b1;
    for (int n = 0; n < 40; n++) begin
      push_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    compare_drain();

`ifdef DMADD_CMD_PARITY_EN
    // ---- parity: bad command dropped, error sticky until CLEAR
    push_cmd(2'b00, 4'd0, 4'd1, 1'b0);
    wait_idle();
    chk("par_clean", par_err, 0);
    push_cmd(2'b01, 4'd7, 4'd6, 1'b1);
    repeat (5) @(negedge clk);
    chk("par_set", par_err, 1);
    chk("par_no_load", act_ld.size(), 0);
    push_cmd(2'b01, 4'd2, 4'd4, 1'b0);
    wait_idle();
    chk("par_sticky", par_err, 1);
    push_cmd(2'b00, 4'd0, 4'd0, 1'b0);
    wait_idle();
    chk("par_cleared", par_err, 0);
    compare_drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish by 500000");
    $fatal(1, "watchdog");
  end

endmodule
